pipe_mac: RTL and testbench

- Parametrised three-stage pipelined multiply-add unit with valid/ready handshake on both sides and a per-transaction mode.
- Mode 0: out = a*b + c.
- Mode 1: out = acc + a*b, where acc is a running accumulator.
- Sits between a producer FIFO and a consumer that may stall; generalises the fixed 3-bit, no-backpressure multiply-add pipe.

---
 rtl/pipe_mac_pkg.sv | 22 ++
 rtl/pipe_mac_slice.sv | 27 ++
 rtl/pipe_mac.sv | 106 ++++++++++
 tb/tb_pipe_mac.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mac_pkg.sv
// Shared types for the pipelined multiply-add / accumulate unit.
package pipe_mac_pkg;

  typedef enum logic {
    MODE_MAC = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  // Per-transaction control that rides along with the operands.
  typedef struct packed {
    mode_e mode;
    logic  clr;
  } ctl_t;

  // The result needs one bit beyond the full product so that p + c cannot overflow.
  localparam int OUT_W_MARGIN = 1;

  function automatic int min_out_w(input int data_w);
    return 2 * data_w + OUT_W_MARGIN;
  endfunction

endpackage

// File: rtl/pipe_mac_slice.sv
// Valid/ready register slice: loads when empty or when downstream takes its content.
module pipe_mac_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_mac.sv
// Three-stage pipelined multiply-add / accumulate with valid/ready on both sides.
// Build option PIPE_MAC_SAT_EN: stage-3 sums and acc saturate instead of wrapping.
module pipe_mac
  import pipe_mac_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  input  logic              in_mode,
  input  logic              in_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  if (OUT_W < min_out_w(DATA_W)) begin : g_width_check
    $error("pipe_mac: OUT_W must be at least 2*DATA_W+1");
  end

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    ctl_t              ctl;
  } s1_t;

  typedef struct packed {
    logic [OUT_W-1:0]  p;
    logic [DATA_W-1:0] c;
    ctl_t              ctl;
  } s2_t;

  s1_t s1_in, s1;
  s2_t s2_in, s2;
  logic v1, v2, ready2, ready3, s3_load;
  logic [2*DATA_W-1:0] prod;
  logic [OUT_W-1:0] base, res, acc;

  // Stage 1: operand capture
  assign s1_in.a        = in_data1;
  assign s1_in.b        = in_data2;
  assign s1_in.c        = in_data3;
  assign s1_in.ctl.mode = mode_e'(in_mode);
  assign s1_in.ctl.clr  = in_clr;

  pipe_mac_slice #(.W($bits(s1_t))) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(s1_in),
    .out_valid(v1), .out_ready(ready2), .out_data(s1)
  );

  // Stage 2: full-width product, zero-extended to the result width
  assign prod     = s1.a * s1.b;
  assign s2_in.p   = OUT_W'(prod);
  assign s2_in.c   = s1.c;
  assign s2_in.ctl = s1.ctl;

  pipe_mac_slice #(.W($bits(s2_t))) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(ready2), .in_data(s2_in),
    .out_valid(v2), .out_ready(ready3), .out_data(s2)
  );

  // Stage 3: add, either the carried addend or the (optionally cleared) accumulator
  always_comb begin
    base = OUT_W'(s2.c);
    if (s2.ctl.mode == MODE_ACC) base = s2.ctl.clr ? '0 : acc;
  end

`ifdef PIPE_MAC_SAT_EN
  logic [OUT_W:0] sum;
  logic           sat_seen;

  assign sum = {1'b0, base} + {1'b0, s2.p};
  assign res = sum[OUT_W] ? '1 : sum[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sat_seen <= 1'b0;
    else if (s3_load && sum[OUT_W])  sat_seen <= 1'b1;
  end
`else
  assign res = base + s2.p;
`endif

  assign s3_load = v2 && ready3;

  pipe_mac_slice #(.W(OUT_W)) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(ready3), .in_data(res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // acc moves only with a mode-1 result entering the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                acc <= '0;
    else if (s3_load && s2.ctl.mode == MODE_ACC) acc <= res;
  end

endmodule

// File: tb/tb_pipe_mac.sv
// Directed bench for pipe_mac with an in-order result model and per-cycle output compare.
module tb_pipe_mac;

  localparam int DATA_W = 3;
  localparam int OUT_W  = 8;
  localparam int OMAX   = (1 << OUT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data1, in_data2, in_data3;
  logic              in_mode, in_clr;
  logic              out_valid, out_ready;
  logic [OUT_W-1:0]  out_data;

  int checks = 0;
  int failures = 0;
  int q[$];
  int got[$];
  int macc = 0;

  pipe_mac #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_mode(in_mode), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int fit(input int v);
`ifdef PIPE_MAC_SAT_EN
    return (v > OMAX) ? OMAX : v;
`else
    return v % (OMAX + 1);
`endif
  endfunction

  // Result of a transaction, computed in acceptance order (the pipe never reorders).
  function automatic int model(input int a, input int b, input int c, input int m, input int clr);
    int r;
    if (m == 0) r = fit(a * b + c);
    else begin
      r = fit((clr != 0 ? 0 : macc) + a * b);
      macc = r;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      macc = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_out: out_data=%0d with nothing expected", out_data);
        end else begin
          chk("stream", int'(out_data), q[0]);
          if (out_ready) begin
            got.push_back(int'(out_data));
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(int'(in_data1), int'(in_data2), int'(in_data3), int'(in_mode), int'(in_clr)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a transaction and return just after the edge that accepts it.
  task automatic send(input int a, input int b, input int c, input int m, input int clr, output int waits);
    in_valid = 1'b1;
    in_data1 = DATA_W'(a);
    in_data2 = DATA_W'(b);
    in_data3 = DATA_W'(c);
    in_mode  = m[0];
    in_clr   = clr[0];
    waits = 0;
    while (!in_ready && waits < 50) begin
      step();
      waits++;
    end
    if (waits >= 50) chk("accept_timeout", waits, 0);
    step();
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      step();
      n++;
    end
    chk("drain_in_time", int'(n < 50), 1);
  endtask

  task automatic expect_got(input string nm, input int n, input int e[6]);
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got.size()) chk(nm, got[i], e[i]);
    got.delete();
  endtask

  int w;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data1 = '0; in_data2 = '0; in_data3 = '0; in_mode = 1'b0; in_clr = 1'b0;
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back mode 0, latency pinned on the first result
    send(7, 7, 7, 0, 0, w);
    send(3, 2, 1, 0, 0, w);
    chk("lat_not_yet", int'(out_valid), 0);
    send(0, 5, 4, 0, 0, w);
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_data", int'(out_data), 56);
    drain();
    expect_got("b2b", 3, '{56, 7, 4, 0, 0, 0});

    // Accumulate with an interleaved mode-0 transaction
    send(2, 3, 0, 1, 1, w);
    send(4, 4, 0, 1, 0, w);
    send(1, 1, 1, 0, 0, w);
    send(1, 1, 5, 1, 0, w);
    drain();
    expect_got("acc", 4, '{6, 22, 2, 23, 0, 0});

    // Backpressure: pipe fills, in_ready drops, head result holds
    out_ready = 1'b0;
    send(1, 2, 3, 0, 0, w);
    send(2, 2, 0, 0, 0, w);
    send(3, 3, 3, 0, 0, w);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_head", int'(out_data), 5);
    in_data1 = 3'd2; in_data2 = 3'd3; in_data3 = 3'd1; in_mode = 1'b0; in_clr = 1'b0;
    step(); step();
    chk("bp_hold", int'(out_data), 5);
    chk("bp_still_blocked", int'(in_ready), 0);
    out_ready = 1'b1;
    step();
    drain();
    expect_got("bp", 4, '{5, 4, 12, 7, 0, 0});

    // Bubble collapse behind a stalled output register
    out_ready = 1'b0;
    send(1, 1, 0, 0, 0, w);
    in_valid = 1'b0;
    step(); step();
    chk("bub_s3_only_ready", int'(in_ready), 1);
    send(2, 2, 0, 0, 0, w);
    chk("bub_accept1_wait", w, 0);
    send(3, 1, 1, 0, 0, w);
    chk("bub_accept2_wait", w, 0);
    in_valid = 1'b0;
    chk("bub_full", int'(in_ready), 0);
    chk("bub_head", int'(out_data), 1);
    drain();
    expect_got("bub", 3, '{1, 4, 4, 0, 0, 0});

    // Accumulate 7*7 six times: wraps or saturates
    send(7, 7, 0, 1, 1, w);
    for (int i = 0; i < 5; i++) send(7, 7, 0, 1, 0, w);
    drain();
`ifdef PIPE_MAC_SAT_EN
    expect_got("sat", 6, '{49, 98, 147, 196, 245, 255});
    chk("sat_acc", int'(dut.acc), 255);
    chk("sat_seen", int'(dut.sat_seen), 1);
`else
    expect_got("wrap", 6, '{49, 98, 147, 196, 245, 38});
    chk("wrap_acc", int'(dut.acc), 38);
`endif

    // Reset with three transactions in flight
    out_ready = 1'b0;
    send(1, 1, 0, 1, 0, w);
    send(1, 1, 0, 1, 0, w);
    send(1, 1, 0, 1, 0, w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    chk("mid_rst_acc", int'(dut.acc), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    step();
    rst_n = 1'b1;
    got.delete();
    out_ready = 1'b1;
    send(1, 1, 0, 1, 0, w);
    drain();
    expect_got("post_rst", 1, '{1, 0, 0, 0, 0, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
